// File: rtl/ethernet_cmd_mac.sv
// Single-clock Ethernet command MAC: RX filter + command decode, TX reply framer with pad and FCS.
// Optional RX FCS verification when RX_FCS_CHECK_EN is defined.
module ethernet_cmd_mac #(
    parameter logic [15:0] ETYPE    = 16'h88B5,
    parameter int          MAXWORDS = 375,
    parameter int          IFG      = 12
) (
    input  logic        clk125,
    input  logic        reset,
    input  logic [47:0] MAC,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    output logic [7:0]  gmii_txd,
    output logic        mac_gmii_tx_en,
    input  logic [31:0] txd,
    input  logic        txvld,
    input  logic        txend,
    output logic        txready,
    output logic [31:0] address,
    output logic [31:0] value,
    output logic [2:0]  cmd,
    input  logic        ready4cmd,
    output logic        error,
    output logic        rcvcnt,
    output logic [4:0]  debug
);

    localparam logic [2:0] RX_IDLE = 3'd0, RX_PRE = 3'd1, RX_HDR = 3'd2, RX_PAY = 3'd3, RX_DROP = 3'd4;
    localparam logic [2:0] TX_IDLE = 3'd0, TX_PRE = 3'd1, TX_HDR = 3'd2, TX_PAY = 3'd3,
                           TX_PAD  = 3'd4, TX_FCS = 3'd5, TX_GAP = 3'd6;

    // Reflected CRC-32 (poly 04C11DB7), one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // ---------------- RX ----------------
    logic [2:0]   rx_state_reg;
    logic [3:0]   rx_cnt_reg;
    logic [103:0] rx_hdr_reg;
    logic [111:0] rx_hdr_next;
    logic [66:0]  rx_pay_reg;
    logic         rx_hdr_ok;
    logic         rx_fcs_ok;
    logic [31:0]  address_reg, value_reg;
    logic [2:0]   cmd_reg;
    logic         rcvcnt_reg, rx_err_reg, rx_dropped_reg;
    logic [47:0]  tx_dest_reg;

    assign rx_hdr_next = {rx_hdr_reg, gmii_rxd};
    assign rx_hdr_ok   = ((rx_hdr_next[111:64] == MAC) || (rx_hdr_next[111:64] == 48'hFFFF_FFFF_FFFF))
                         && (rx_hdr_next[15:0] == ETYPE);

`ifdef RX_FCS_CHECK_EN
    logic [31:0] rx_crc_reg;
    logic [31:0] rx_crc_rev;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_crc_rev
            assign rx_crc_rev[gi] = rx_crc_reg[31-gi];
        end
    endgenerate

    assign rx_fcs_ok = (rx_crc_rev == 32'hC704DD7B);

    always_ff @(posedge clk125) begin
        if (reset)
            rx_crc_reg <= 32'hFFFF_FFFF;
        else if (gmii_rx_dv) begin
            if (rx_state_reg == RX_PRE)
                rx_crc_reg <= 32'hFFFF_FFFF;
            else if (rx_state_reg == RX_HDR || rx_state_reg == RX_PAY)
                rx_crc_reg <= crc_byte(rx_crc_reg, gmii_rxd);
        end
    end
`else
    assign rx_fcs_ok = 1'b1;
`endif

    always_ff @(posedge clk125) begin
        if (reset) begin
            rx_state_reg   <= RX_IDLE;
            rx_cnt_reg     <= '0;
            rx_hdr_reg     <= '0;
            rx_pay_reg     <= '0;
            address_reg    <= '0;
            value_reg      <= '0;
            cmd_reg        <= '0;
            rcvcnt_reg     <= 1'b0;
            rx_err_reg     <= 1'b0;
            rx_dropped_reg <= 1'b0;
            tx_dest_reg    <= 48'hFFFF_FFFF_FFFF;
        end else begin
            cmd_reg    <= '0;
            rx_err_reg <= 1'b0;
            if (!gmii_rx_dv) begin
                // End of frame: every state falls back to IDLE; only HDR/PAY have something to report.
                rx_state_reg <= RX_IDLE;
                if (rx_state_reg == RX_HDR || (rx_state_reg == RX_PAY && (rx_cnt_reg < 4'd9 || !rx_fcs_ok))) begin
                    rx_err_reg     <= 1'b1;
                    rx_dropped_reg <= 1'b1;
                end else if (rx_state_reg == RX_PAY) begin
                    if (rx_pay_reg[66:64] != 3'd0 && !ready4cmd) begin
                        rx_err_reg <= 1'b1;
                    end else begin
                        address_reg    <= rx_pay_reg[63:32];
                        value_reg      <= rx_pay_reg[31:0];
                        cmd_reg        <= rx_pay_reg[66:64];
                        rcvcnt_reg     <= ~rcvcnt_reg;
                        tx_dest_reg    <= rx_hdr_reg[63:16];
                        rx_dropped_reg <= 1'b0;
                    end
                end
            end else begin
                case (rx_state_reg)
                    RX_IDLE: rx_state_reg <= RX_PRE;
                    RX_PRE: begin
                        rx_cnt_reg <= '0;
                        if (gmii_rxd == 8'hD5)
                            rx_state_reg <= RX_HDR;
                        else if (gmii_rxd != 8'h55)
                            rx_state_reg <= RX_DROP;
                    end
                    RX_HDR: begin
                        rx_hdr_reg <= rx_hdr_next[103:0];
                        rx_cnt_reg <= rx_cnt_reg + 4'd1;
                        if (rx_cnt_reg == 4'd13) begin
                            rx_cnt_reg   <= '0;
                            rx_state_reg <= rx_hdr_ok ? RX_PAY : RX_DROP;
                        end
                    end
                    RX_PAY: begin
                        if (rx_cnt_reg < 4'd9) begin
                            rx_pay_reg <= {rx_pay_reg[58:0], gmii_rxd};
                            rx_cnt_reg <= rx_cnt_reg + 4'd1;
                        end
                    end
                    RX_DROP: rx_state_reg <= RX_DROP;
                    default: rx_state_reg <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- TX ----------------
    logic [2:0]   tx_state_reg;
    logic [7:0]   tx_cnt_reg;
    logic [31:0]  tx_word_reg;
    logic         tx_last_reg;
    logic [15:0]  tx_words_reg;
    logic [10:0]  tx_pay_reg;
    logic [111:0] tx_sh_reg;
    logic [31:0]  tx_crc_reg;
    logic [7:0]   gmii_txd_reg;
    logic         tx_en_reg, tx_err_reg;
    logic         tx_take;

    // Next word is requested only while the last byte of a non-final word is being loaded.
    assign txready = !reset && ((tx_state_reg == TX_IDLE) ||
                     (tx_state_reg == TX_PAY && tx_cnt_reg == 8'd3 && !tx_last_reg &&
                      tx_words_reg < 16'(MAXWORDS)));
    assign tx_take = txready && txvld;

    always_ff @(posedge clk125) begin
        if (reset) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_word_reg  <= '0;
            tx_last_reg  <= 1'b0;
            tx_words_reg <= '0;
            tx_pay_reg   <= '0;
            tx_sh_reg    <= '0;
            tx_crc_reg   <= '0;
            gmii_txd_reg <= '0;
            tx_en_reg    <= 1'b0;
            tx_err_reg   <= 1'b0;
        end else begin
            tx_err_reg <= 1'b0;
            tx_cnt_reg <= tx_cnt_reg + 8'd1;
            case (tx_state_reg)
                TX_IDLE: begin
                    tx_en_reg    <= 1'b0;
                    gmii_txd_reg <= '0;
                    tx_cnt_reg   <= '0;
                    if (tx_take) begin
                        tx_word_reg  <= txd;
                        tx_last_reg  <= txend;
                        tx_words_reg <= 16'd1;
                        tx_state_reg <= TX_PRE;
                    end
                end
                TX_PRE: begin
                    tx_en_reg    <= 1'b1;
                    gmii_txd_reg <= (tx_cnt_reg == 8'd7) ? 8'hD5 : 8'h55;
                    if (tx_cnt_reg == 8'd7) begin
                        tx_cnt_reg   <= '0;
                        tx_crc_reg   <= 32'hFFFF_FFFF;
                        tx_sh_reg    <= {tx_dest_reg, MAC, ETYPE};
                        tx_state_reg <= TX_HDR;
                    end
                end
                TX_HDR: begin
                    gmii_txd_reg <= tx_sh_reg[111:104];
                    tx_crc_reg   <= crc_byte(tx_crc_reg, tx_sh_reg[111:104]);
                    tx_sh_reg    <= {tx_sh_reg[103:0], 8'h00};
                    if (tx_cnt_reg == 8'd13) begin
                        tx_cnt_reg   <= '0;
                        tx_pay_reg   <= '0;
                        tx_state_reg <= TX_PAY;
                    end
                end
                TX_PAY: begin
                    gmii_txd_reg <= tx_word_reg[31:24];
                    tx_crc_reg   <= crc_byte(tx_crc_reg, tx_word_reg[31:24]);
                    tx_word_reg  <= {tx_word_reg[23:0], 8'h00};
                    tx_pay_reg   <= tx_pay_reg + 11'd1;
                    if (tx_cnt_reg == 8'd3) begin
                        tx_cnt_reg <= '0;
                        if (tx_take) begin
                            tx_word_reg  <= txd;
                            tx_last_reg  <= txend;
                            tx_words_reg <= tx_words_reg + 16'd1;
                        end else begin
                            // Underrun or word limit ends the frame early.
                            tx_err_reg   <= !tx_last_reg;
                            tx_state_reg <= (tx_pay_reg < 11'd45) ? TX_PAD : TX_FCS;
                        end
                    end
                end
                TX_PAD: begin
                    gmii_txd_reg <= 8'h00;
                    tx_crc_reg   <= crc_byte(tx_crc_reg, 8'h00);
                    tx_pay_reg   <= tx_pay_reg + 11'd1;
                    tx_cnt_reg   <= '0;
                    if (tx_pay_reg >= 11'd45)
                        tx_state_reg <= TX_FCS;
                end
                TX_FCS: begin
                    gmii_txd_reg <= ~tx_crc_reg[7:0];
                    tx_crc_reg   <= {8'h00, tx_crc_reg[31:8]};
                    if (tx_cnt_reg == 8'd3) begin
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    tx_en_reg    <= 1'b0;
                    gmii_txd_reg <= '0;
                    if (tx_cnt_reg == 8'(IFG - 1))
                        tx_state_reg <= TX_IDLE;
                end
                default: tx_state_reg <= TX_IDLE;
            endcase
        end
    end

    assign gmii_txd       = gmii_txd_reg;
    assign mac_gmii_tx_en = tx_en_reg;
    assign address        = address_reg;
    assign value          = value_reg;
    assign cmd            = cmd_reg;
    assign rcvcnt         = rcvcnt_reg;
    assign error          = rx_err_reg | tx_err_reg;
    assign debug          = {rx_dropped_reg, tx_state_reg != TX_IDLE, rx_state_reg};

endmodule

// File: tb/tb_ethernet_cmd_mac.sv
// Directed-vector bench for ethernet_cmd_mac: RX filtering/decode, runts, TX framing, back-to-back, reset.
module tb_ethernet_cmd_mac;
    logic        clk125 = 1'b0;
    logic        reset;
    logic [47:0] MAC;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_txd;
    logic        mac_gmii_tx_en;
    logic [31:0] txd;
    logic        txvld, txend, txready;
    logic [31:0] address, value;
    logic [2:0]  cmd;
    logic        ready4cmd, error, rcvcnt;
    logic [4:0]  debug;

    always #4 clk125 = ~clk125;

    ethernet_cmd_mac dut (
        .clk125(clk125), .reset(reset), .MAC(MAC),
        .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
        .gmii_txd(gmii_txd), .mac_gmii_tx_en(mac_gmii_tx_en),
        .txd(txd), .txvld(txvld), .txend(txend), .txready(txready),
        .address(address), .value(value), .cmd(cmd), .ready4cmd(ready4cmd),
        .error(error), .rcvcnt(rcvcnt), .debug(debug)
    );

    localparam logic [47:0] OWN   = 48'h8037_5500_4318;
    localparam logic [47:0] SRC   = 48'h0200_0000_0001;
    localparam logic [47:0] SRC_B = 48'h0200_0000_0007;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  rx_q[$];
    int          cmd_cycles, err_cycles, cmd_at;
    logic [2:0]  cmd_last;

    logic [31:0] w_q[$];
    logic        e_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          len_q[$];
    int          gap_q[$];
    int          busy_bad, idle_nz;

    task automatic tick;
        @(posedge clk125);
        #1;
    endtask

    task automatic rx_build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
        rx_q.delete();
        repeat (7) rx_q.push_back(8'h55);
        rx_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) rx_q.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) rx_q.push_back(src[8*i +: 8]);
        rx_q.push_back(et[15:8]);
        rx_q.push_back(et[7:0]);
    endtask

    task automatic rx_mon(input int idx);
        if (cmd !== 3'd0) begin
            cmd_cycles++;
            cmd_last = cmd;
            if (cmd_at < 0) cmd_at = idx;
        end
        if (error === 1'b1) err_cycles++;
    endtask

    task automatic rx_send;
        cmd_cycles = 0; err_cycles = 0; cmd_at = -1; cmd_last = 3'd0;
        for (int i = 0; i < rx_q.size(); i++) begin
            gmii_rx_dv = 1'b1;
            gmii_rxd   = rx_q[i];
            tick;
            rx_mon(-1);
        end
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        for (int i = 0; i < 6; i++) begin
            tick;
            rx_mon(i);
        end
        $display("rx frame %0d bytes: cmd=%0d cmd_cycles=%0d err_cycles=%0d addr=%h val=%h rcvcnt=%b",
                 rx_q.size(), cmd_last, cmd_cycles, err_cycles, address, value, rcvcnt);
    endtask

    // Expected TX frame: preamble, header, words, zero pad to 46 payload bytes, FCS LSB first.
    task automatic exp_frame(input logic [47:0] dst, input int wfirst, input int wcount);
        int start, npay;
        logic [31:0] c;
        logic fb;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        start = exp_q.size();
        for (int i = 5; i >= 0; i--) exp_q.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(OWN[8*i +: 8]);
        exp_q.push_back(8'h88);
        exp_q.push_back(8'hB5);
        npay = 0;
        for (int w = wfirst; w < wfirst + wcount; w++)
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w_q[w][8*b +: 8]);
                npay++;
            end
        while (npay < 46) begin
            exp_q.push_back(8'h00);
            npay++;
        end
        c = 32'hFFFF_FFFF;
        for (int i = start; i < exp_q.size(); i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ exp_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        c = ~c;
        for (int b = 0; b < 4; b++) exp_q.push_back(c[8*b +: 8]);
    endtask

    task automatic tx_run(input int cycles);
        int widx, cur, gap;
        logic en_prev, acc, seen;
        got_q.delete(); len_q.delete(); gap_q.delete();
        busy_bad = 0; idle_nz = 0; widx = 0; cur = 0; gap = 0; en_prev = 1'b0; seen = 1'b0;
        txvld = 1'b1; txd = w_q[0]; txend = e_q[0];
        for (int c = 0; c < cycles; c++) begin
            acc = txvld && txready;
            tick;
            if (acc) begin
                widx++;
                if (widx < w_q.size()) begin
                    txd = w_q[widx]; txend = e_q[widx];
                end else begin
                    txvld = 1'b0; txd = '0; txend = 1'b0;
                end
            end
            if (mac_gmii_tx_en === 1'b1) begin
                if (!en_prev && seen) gap_q.push_back(gap);
                got_q.push_back(gmii_txd);
                cur++;
                if (debug[3] !== 1'b1) busy_bad++;
            end else begin
                if (en_prev) begin
                    len_q.push_back(cur);
                    $display("tx frame %0d: %0d bytes", len_q.size(), cur);
                    cur = 0; gap = 0; seen = 1'b1;
                end
                gap++;
                if (gmii_txd !== 8'h00) idle_nz++;
            end
            en_prev = mac_gmii_tx_en;
        end
        txvld = 1'b0; txd = '0; txend = 1'b0;
    endtask

    task automatic check_tx_bytes;
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL tx_byte_count: got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL tx_byte[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (busy_bad !== 0) begin n_bad++; $display("FAIL tx_busy_flag: %0d bytes with debug[3]=0, want 0", busy_bad); end
        n_cmp++;
        if (idle_nz !== 0) begin n_bad++; $display("FAIL tx_idle_data: %0d nonzero idle bytes, want 0", idle_nz); end
    endtask

    task automatic test_reset;
        reset = 1'b1; MAC = OWN; gmii_rxd = '0; gmii_rx_dv = 1'b0;
        txd = '0; txvld = 1'b0; txend = 1'b0; ready4cmd = 1'b1;
        repeat (3) tick;
        n_cmp++;
        if ({gmii_txd, mac_gmii_tx_en, address, value, cmd, error, rcvcnt, debug} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: txd=%h en=%b addr=%h val=%h cmd=%0d err=%b rcv=%b dbg=%b, want all 0",
                     gmii_txd, mac_gmii_tx_en, address, value, cmd, error, rcvcnt, debug);
        end
        n_cmp++;
        if (txready !== 1'b0) begin n_bad++; $display("FAIL reset_txready: got %b want 0", txready); end
        reset = 1'b0;
        tick;
        n_cmp++;
        if (txready !== 1'b1) begin n_bad++; $display("FAIL post_reset_txready: got %b want 1", txready); end
        $display("reset done");
    endtask

    task automatic test_filter;
        logic r0;
        r0 = rcvcnt;
        for (int k = 0; k < 10; k++) begin
            rx_build(48'h8081_8283_8485, SRC, 16'h0800);
            for (int p = 0; p < 100; p++) rx_q.push_back(8'(p));
            rx_send;
            n_cmp++;
            if (cmd_cycles !== 0) begin n_bad++; $display("FAIL filter_cmd[%0d]: got %0d cmd cycles want 0", k, cmd_cycles); end
            n_cmp++;
            if (err_cycles !== 0) begin n_bad++; $display("FAIL filter_err[%0d]: got %0d err cycles want 0", k, err_cycles); end
            repeat (200) tick;
        end
        n_cmp++;
        if (rcvcnt !== r0) begin n_bad++; $display("FAIL filter_rcvcnt: got %b want %b", rcvcnt, r0); end
        n_cmp++;
        if (debug[2:0] !== 3'd0) begin n_bad++; $display("FAIL filter_rx_idle: got %0d want 0", debug[2:0]); end
    endtask

    task automatic test_cmd;
        logic r0;
        r0 = rcvcnt;
        ready4cmd = 1'b1;
        rx_build(OWN, SRC, 16'h88B5);
        rx_q.push_back(8'h03); rx_q.push_back(8'h12); rx_q.push_back(8'h34); rx_q.push_back(8'h56);
        rx_q.push_back(8'h78); rx_q.push_back(8'hDE); rx_q.push_back(8'hAD); rx_q.push_back(8'hBE);
        rx_q.push_back(8'hEF);
        rx_send;
        n_cmp++;
        if (cmd_cycles !== 1 || cmd_last !== 3'd3) begin
            n_bad++; $display("FAIL cmd_pulse: got cmd=%0d for %0d cycles want 3 for 1", cmd_last, cmd_cycles);
        end
        n_cmp++;
        if (cmd_at !== 0) begin n_bad++; $display("FAIL cmd_timing: got offset %0d want 0", cmd_at); end
        n_cmp++;
        if (address !== 32'h1234_5678) begin n_bad++; $display("FAIL cmd_address: got %h want 12345678", address); end
        n_cmp++;
        if (value !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL cmd_value: got %h want deadbeef", value); end
        n_cmp++;
        if (rcvcnt !== ~r0) begin n_bad++; $display("FAIL cmd_rcvcnt: got %b want %b", rcvcnt, ~r0); end
        n_cmp++;
        if (err_cycles !== 0) begin n_bad++; $display("FAIL cmd_error: got %0d err cycles want 0", err_cycles); end
    endtask

    task automatic test_cmd_not_ready;
        logic r0;
        r0 = rcvcnt;
        ready4cmd = 1'b0;
        rx_build(OWN, SRC, 16'h88B5);
        rx_q.push_back(8'h05); rx_q.push_back(8'hAA); rx_q.push_back(8'hBB); rx_q.push_back(8'hCC);
        rx_q.push_back(8'hDD); rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
        rx_q.push_back(8'h44);
        rx_send;
        ready4cmd = 1'b1;
        n_cmp++;
        if (cmd_cycles !== 0) begin n_bad++; $display("FAIL notready_cmd: got %0d cmd cycles want 0", cmd_cycles); end
        n_cmp++;
        if (err_cycles !== 1) begin n_bad++; $display("FAIL notready_error: got %0d err cycles want 1", err_cycles); end
        n_cmp++;
        if (address !== 32'h1234_5678) begin n_bad++; $display("FAIL notready_address: got %h want 12345678", address); end
        n_cmp++;
        if (rcvcnt !== r0) begin n_bad++; $display("FAIL notready_rcvcnt: got %b want %b", rcvcnt, r0); end
    endtask

    task automatic test_broadcast;
        logic r0;
        r0 = rcvcnt;
        rx_build(48'hFFFF_FFFF_FFFF, SRC_B, 16'h88B5);
        rx_q.push_back(8'h07); rx_q.push_back(8'hCA); rx_q.push_back(8'hFE); rx_q.push_back(8'h00);
        rx_q.push_back(8'h01); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        rx_q.push_back(8'h2A);
        for (int i = 0; i < 4; i++) rx_q.push_back(8'h99);
        rx_send;
        n_cmp++;
        if (cmd_cycles !== 1 || cmd_last !== 3'd7) begin
            n_bad++; $display("FAIL bcast_cmd: got cmd=%0d for %0d cycles want 7 for 1", cmd_last, cmd_cycles);
        end
        n_cmp++;
        if (address !== 32'hCAFE_0001 || value !== 32'h0000_002A) begin
            n_bad++; $display("FAIL bcast_data: got %h/%h want cafe0001/0000002a", address, value);
        end
        n_cmp++;
        if (rcvcnt !== ~r0) begin n_bad++; $display("FAIL bcast_rcvcnt: got %b want %b", rcvcnt, ~r0); end
    endtask

    task automatic test_runt;
        logic r0;
        r0 = rcvcnt;
        rx_build(OWN, SRC, 16'h88B5);
        for (int i = 1; i <= 5; i++) rx_q.push_back(8'(i));
        rx_send;
        n_cmp++;
        if (err_cycles !== 1) begin n_bad++; $display("FAIL runt_error: got %0d err cycles want 1", err_cycles); end
        n_cmp++;
        if (cmd_cycles !== 0) begin n_bad++; $display("FAIL runt_cmd: got %0d cmd cycles want 0", cmd_cycles); end
        n_cmp++;
        if (debug[4] !== 1'b1) begin n_bad++; $display("FAIL runt_dropped: got %b want 1", debug[4]); end
        n_cmp++;
        if (rcvcnt !== r0) begin n_bad++; $display("FAIL runt_rcvcnt: got %b want %b", rcvcnt, r0); end
        // A good command afterwards clears the dropped flag and makes SRC the reply destination.
        rx_build(OWN, SRC, 16'h88B5);
        rx_q.push_back(8'h02); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        rx_q.push_back(8'h10); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
        rx_q.push_back(8'h20);
        rx_send;
        n_cmp++;
        if (cmd_last !== 3'd2 || address !== 32'h10 || value !== 32'h20) begin
            n_bad++; $display("FAIL recover_cmd: got cmd=%0d %h/%h want 2 00000010/00000020", cmd_last, address, value);
        end
        n_cmp++;
        if (debug[4] !== 1'b0) begin n_bad++; $display("FAIL recover_dropped: got %b want 0", debug[4]); end
    endtask

    task automatic test_tx;
        w_q = '{32'h1122_3344, 32'h5566_7788};
        e_q = '{1'b0, 1'b1};
        exp_q.delete();
        exp_frame(SRC, 0, 2);
        tx_run(200);
        n_cmp++;
        if (len_q.size() !== 1) begin
            n_bad++; $display("FAIL tx_frames: got %0d frames want 1", len_q.size());
        end else begin
            n_cmp++;
            if (len_q[0] !== 72) begin n_bad++; $display("FAIL tx_len: got %0d want 72", len_q[0]); end
        end
        check_tx_bytes;
    endtask

    task automatic test_back_to_back;
        w_q = '{32'hAABB_CCDD, 32'h0102_0304};
        e_q = '{1'b1, 1'b1};
        exp_q.delete();
        exp_frame(SRC, 0, 1);
        exp_frame(SRC, 1, 1);
        tx_run(300);
        n_cmp++;
        if (len_q.size() !== 2) begin
            n_bad++; $display("FAIL b2b_frames: got %0d frames want 2", len_q.size());
        end else begin
            n_cmp++;
            if (len_q[0] !== 72 || len_q[1] !== 72) begin
                n_bad++; $display("FAIL b2b_len: got %0d,%0d want 72,72", len_q[0], len_q[1]);
            end
        end
        n_cmp++;
        if (gap_q.size() !== 1) begin
            n_bad++; $display("FAIL b2b_gap_seen: got %0d gaps want 1", gap_q.size());
        end else begin
            n_cmp++;
            if (gap_q[0] < 12) begin n_bad++; $display("FAIL b2b_gap: got %0d idle cycles want >=12", gap_q[0]); end
        end
        check_tx_bytes;
    endtask

    task automatic test_reset_mid_tx;
        int cnt, en_hi;
        txd = 32'hCAFE_BABE; txend = 1'b1; txvld = 1'b1;
        tick;
        txvld = 1'b0; txend = 1'b0; txd = '0;
        cnt = 0;
        while (mac_gmii_tx_en !== 1'b1 && cnt < 20) begin tick; cnt++; end
        n_cmp++;
        if (mac_gmii_tx_en !== 1'b1) begin n_bad++; $display("FAIL midtx_start: got en=%b want 1", mac_gmii_tx_en); end
        repeat (20) tick;
        reset = 1'b1;
        tick;
        n_cmp++;
        if (mac_gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) begin
            n_bad++; $display("FAIL midtx_stop: got en=%b txd=%h want 0/00", mac_gmii_tx_en, gmii_txd);
        end
        repeat (2) tick;
        n_cmp++;
        if (txready !== 1'b0) begin n_bad++; $display("FAIL midtx_txready_reset: got %b want 0", txready); end
        reset = 1'b0;
        tick;
        n_cmp++;
        if (txready !== 1'b1) begin n_bad++; $display("FAIL midtx_txready_after: got %b want 1", txready); end
        en_hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (mac_gmii_tx_en !== 1'b0) en_hi++;
        end
        n_cmp++;
        if (en_hi !== 0) begin n_bad++; $display("FAIL midtx_no_resume: got %0d en cycles want 0", en_hi); end
        $display("reset mid-tx done");
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_filter;
        test_cmd;
        test_cmd_not_ready;
        test_broadcast;
        test_runt;
        test_tx;
        test_back_to_back;
        test_reset_mid_tx;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
